// File: rtl/can_tx_scheduler_pkg.sv
// Shared definitions for the CAN transmit mailbox scheduler.
//   ID_SIZE / DATA_SIZE   : CAN identifier and payload widths
//   NUM_MBOX_DEFAULT      : default number of transmit mailboxes
//   MAX_RETRY_DEFAULT     : default failed attempts before a frame is dropped
//   sched_state_t         : scheduler FSM state encoding
package can_tx_scheduler_pkg;

  localparam int ID_SIZE           = 11;
  localparam int DATA_SIZE         = 64;
  localparam int NUM_MBOX_DEFAULT  = 4;
  localparam int MAX_RETRY_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECT    = 2'd1,
    PRESENT   = 2'd2,
    IN_FLIGHT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/can_tx_scheduler_prio_pick.sv
// can_prio_pick: combinational arbiter over the pending mailboxes.
// Winner is the lowest ID among pending mailboxes; an ID tie goes to the
// lowest mailbox index.
// Ports:
//   pending     in  per-mailbox pending flags
//   ids         in  per-mailbox frame IDs (packed, index 0 in the low slice)
//   win_idx     out index of the winning mailbox (0 when nothing is pending)
//   any_pending out at least one mailbox is pending
module can_prio_pick
  import can_tx_scheduler_pkg::*;
#(
  parameter int NUM_MBOX = NUM_MBOX_DEFAULT,
  localparam int IDX_W   = $clog2(NUM_MBOX)
) (
  input  logic [NUM_MBOX-1:0]             pending,
  input  logic [NUM_MBOX-1:0][ID_SIZE-1:0] ids,
  output logic [IDX_W-1:0]                win_idx,
  output logic                            any_pending
);

  logic [ID_SIZE-1:0] best_id;
  logic               found;

  always_comb begin
    win_idx = '0;
    best_id = '1;
    found   = 1'b0;
    // Strict less-than keeps the earlier (lower) index on an ID tie.
    for (int i = 0; i < NUM_MBOX; i++) begin
      if (pending[i] && (!found || ids[i] < best_id)) begin
        win_idx = IDX_W'(i);
        best_id = ids[i];
        found   = 1'b1;
      end
    end
    any_pending = found;
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: per-node transmit mailbox scheduler in front of one CAN
// node. Holds NUM_MBOX frames, presents the lowest-ID pending frame on
// Tx_ID/In_packet, re-arbitrates after every failed attempt and drops a
// frame after MAX_RETRY failures.
// Optional feature macro: SCHED_STATS_EN adds saturating 16-bit counters
// stat_sent, stat_retry and stat_abort.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   load_*                 mailbox write (load_ready gates acceptance)
//   mbox_pending           per-mailbox pending flags
//   data_in_req            node takes the presented frame
//   Retransmit / tx_ok     node reports failure / success of the attempt
//   tx_valid/Tx_ID/In_packet  frame presented to the node
//   done_pulse/abort_pulse/evt_idx  completion events
//   fsm_state              scheduler state, for observation
// NUM_MBOX is expected to be a power of two (>= 2).
// Handshake: a load is accepted on a rising edge where load_valid && load_ready;
// load_ready is combinational and drops only while load_idx addresses the
// mailbox currently presented or in flight. A presented frame is taken on a
// rising edge where tx_valid && data_in_req in PRESENT.
module can_tx_scheduler
  import can_tx_scheduler_pkg::*;
#(
  parameter int NUM_MBOX  = NUM_MBOX_DEFAULT,
  parameter int MAX_RETRY = MAX_RETRY_DEFAULT,
  localparam int IDX_W    = $clog2(NUM_MBOX)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [IDX_W-1:0]     load_idx,
  input  logic [ID_SIZE-1:0]   load_id,
  input  logic [DATA_SIZE-1:0] load_data,
  output logic                 load_ready,
  output logic [NUM_MBOX-1:0]  mbox_pending,
  input  logic                 data_in_req,
  input  logic                 Retransmit,
  input  logic                 tx_ok,
  output logic                 tx_valid,
  output logic [ID_SIZE-1:0]   Tx_ID,
  output logic [DATA_SIZE-1:0] In_packet,
  output logic                 done_pulse,
  output logic                 abort_pulse,
  output logic [IDX_W-1:0]     evt_idx,
`ifdef SCHED_STATS_EN
  output logic [15:0]          stat_sent,
  output logic [15:0]          stat_retry,
  output logic [15:0]          stat_abort,
`endif
  output sched_state_t         fsm_state
);

  localparam int RC_W = $clog2(MAX_RETRY + 1);

  logic [NUM_MBOX-1:0][ID_SIZE-1:0] mb_id;
  logic [DATA_SIZE-1:0]             mb_data [NUM_MBOX];
  logic [RC_W-1:0]                  retry   [NUM_MBOX];
  logic [NUM_MBOX-1:0]              pending;
  logic [IDX_W-1:0]                 cur_idx;
  logic [IDX_W-1:0]                 win_idx;
  logic                             any_pending;
  logic                             load_ok;
  logic                             ev_done;
  logic                             ev_abort;
  logic                             ev_retry;
  logic                             last_try;

  assign mbox_pending = pending;

  always_comb begin
    load_ready = !(((fsm_state == PRESENT) || (fsm_state == IN_FLIGHT)) &&
                   (load_idx == cur_idx));
    load_ok  = load_valid && load_ready;
    last_try = (retry[cur_idx] == RC_W'(MAX_RETRY - 1));
    // tx_ok takes precedence over a simultaneous Retransmit.
    ev_done  = (fsm_state == IN_FLIGHT) && tx_ok;
    ev_abort = (fsm_state == IN_FLIGHT) && !tx_ok && Retransmit && last_try;
    ev_retry = (fsm_state == IN_FLIGHT) && !tx_ok && Retransmit && !last_try;
  end

  can_prio_pick #(.NUM_MBOX(NUM_MBOX)) u_pick (
    .pending     (pending),
    .ids         (mb_id),
    .win_idx     (win_idx),
    .any_pending (any_pending)
  );

  // Mailbox payload storage; the in-flight slot can never be written here
  // because load_ready blocks it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mb_id <= '0;
      for (int i = 0; i < NUM_MBOX; i++) mb_data[i] <= '0;
    end else if (load_ok) begin
      mb_id[load_idx]   <= load_id;
      mb_data[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_state   <= IDLE;
      pending     <= '0;
      for (int i = 0; i < NUM_MBOX; i++) retry[i] <= '0;
      cur_idx     <= '0;
      Tx_ID       <= '0;
      In_packet   <= '0;
      tx_valid    <= 1'b0;
      done_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      evt_idx     <= '0;
    end else begin
      done_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      if (load_ok) begin
        pending[load_idx] <= 1'b1;
        retry[load_idx]   <= '0;
      end
      case (fsm_state)
        IDLE: if (any_pending) fsm_state <= SELECT;
        SELECT: begin
          if (any_pending) begin
            cur_idx   <= win_idx;
            Tx_ID     <= mb_id[win_idx];
            In_packet <= mb_data[win_idx];
            tx_valid  <= 1'b1;
            fsm_state <= PRESENT;
          end else begin
            fsm_state <= IDLE;
          end
        end
        PRESENT: if (data_in_req) fsm_state <= IN_FLIGHT;
        IN_FLIGHT: begin
          if (ev_done || ev_abort) begin
            pending[cur_idx] <= 1'b0;
            retry[cur_idx]   <= '0;
            done_pulse       <= ev_done;
            abort_pulse      <= ev_abort;
            evt_idx          <= cur_idx;
            tx_valid         <= 1'b0;
            fsm_state        <= IDLE;
          end else if (ev_retry) begin
            // Back to SELECT so a newly loaded lower ID can preempt.
            retry[cur_idx] <= retry[cur_idx] + RC_W'(1);
            tx_valid       <= 1'b0;
            fsm_state      <= SELECT;
          end
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_sent  <= '0;
      stat_retry <= '0;
      stat_abort <= '0;
    end else begin
      if (ev_done  && stat_sent  != 16'hFFFF) stat_sent  <= stat_sent  + 16'd1;
      if (ev_retry && stat_retry != 16'hFFFF) stat_retry <= stat_retry + 16'd1;
      if (ev_abort && stat_abort != 16'hFFFF) stat_abort <= stat_abort + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Testbench for can_tx_scheduler (NUM_MBOX=4, MAX_RETRY=3).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_can_tx_scheduler;
  import can_tx_scheduler_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 load_valid;
  logic [1:0]           load_idx;
  logic [ID_SIZE-1:0]   load_id;
  logic [DATA_SIZE-1:0] load_data;
  logic                 load_ready;
  logic [3:0]           mbox_pending;
  logic                 data_in_req;
  logic                 Retransmit;
  logic                 tx_ok;
  logic                 tx_valid;
  logic [ID_SIZE-1:0]   Tx_ID;
  logic [DATA_SIZE-1:0] In_packet;
  logic                 done_pulse;
  logic                 abort_pulse;
  logic [1:0]           evt_idx;
  sched_state_t         fsm_state;
`ifdef SCHED_STATS_EN
  logic [15:0]          stat_sent, stat_retry, stat_abort;
  int                   exp_sent, exp_retry, exp_abort;
`endif

  int checks;
  int errors;

  logic [ID_SIZE-1:0]   exp_id_q[$];
  logic [DATA_SIZE-1:0] exp_data_q[$];
  logic [1:0]           exp_evt_q[$];

  can_tx_scheduler #(.NUM_MBOX(4), .MAX_RETRY(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_idx     (load_idx),
    .load_id      (load_id),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .mbox_pending (mbox_pending),
    .data_in_req  (data_in_req),
    .Retransmit   (Retransmit),
    .tx_ok        (tx_ok),
    .tx_valid     (tx_valid),
    .Tx_ID        (Tx_ID),
    .In_packet    (In_packet),
    .done_pulse   (done_pulse),
    .abort_pulse  (abort_pulse),
    .evt_idx      (evt_idx),
`ifdef SCHED_STATS_EN
    .stat_sent    (stat_sent),
    .stat_retry   (stat_retry),
    .stat_abort   (stat_abort),
`endif
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic do_load(input logic [1:0] idx, input logic [ID_SIZE-1:0] id,
                         input logic [DATA_SIZE-1:0] d);
    load_valid = 1'b1; load_idx = idx; load_id = id; load_data = d;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic request();
    data_in_req = 1'b1;
    @(negedge clock);
    data_in_req = 1'b0;
  endtask

  task automatic finish_attempt(input bit ok_, input bit fail_);
    tx_ok = ok_; Retransmit = fail_;
    @(negedge clock);
    tx_ok = 1'b0; Retransmit = 1'b0;
  endtask

  // Takes one presented frame through an attempt and reports what was seen.
  task automatic serve(input bit ok_, input bit fail_, output bit got,
                       output logic [ID_SIZE-1:0] tid, output logic [DATA_SIZE-1:0] tdat,
                       output bit dn, output bit ab, output logic [1:0] ev);
    wait_valid(got);
    tid = Tx_ID; tdat = In_packet;
    request();
    finish_attempt(ok_, fail_);
    dn = done_pulse; ab = abort_pulse; ev = evt_idx;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
    checks++; if (Tx_ID !== '0) begin errors++; $display("FAIL reset_tx_id: got %h exp 000", Tx_ID); end
    checks++; if (In_packet !== '0) begin errors++; $display("FAIL reset_in_packet: got %h exp 0", In_packet); end
    checks++; if (mbox_pending !== 4'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0000", mbox_pending); end
    checks++; if (done_pulse !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b exp 00", done_pulse, abort_pulse); end
    checks++; if (evt_idx !== 2'd0) begin errors++; $display("FAIL reset_evt_idx: got %0d exp 0", evt_idx); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b exp 1", load_ready); end
  endtask

  task automatic test_priority();
    bit got, dn, ab; logic [ID_SIZE-1:0] tid; logic [DATA_SIZE-1:0] tdat; logic [1:0] ev;
    logic [ID_SIZE-1:0] e_id; logic [DATA_SIZE-1:0] e_d; logic [1:0] e_ev;
    logic [DATA_SIZE-1:0] da, db;
    da = {$urandom, $urandom}; db = {$urandom, $urandom};
    exp_id_q.push_back(11'h111); exp_data_q.push_back(db); exp_evt_q.push_back(2'd2);
    exp_id_q.push_back(11'h7FF); exp_data_q.push_back(da); exp_evt_q.push_back(2'd0);
    do_load(2'd2, 11'h111, db);   // edge N
    do_load(2'd0, 11'h7FF, da);   // edge N+1
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: tx_valid got %b exp 0", tx_valid); end
    @(negedge clock);             // after edge N+2
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL latency_n2: tx_valid got %b exp 1", tx_valid); end
    checks++; if (mbox_pending !== 4'b0101) begin errors++; $display("FAIL prio_pending: got %b exp 0101", mbox_pending); end
    for (int n = 0; n < 2; n++) begin
      serve(1'b1, 1'b0, got, tid, tdat, dn, ab, ev);
      e_id = exp_id_q.pop_front(); e_d = exp_data_q.pop_front(); e_ev = exp_evt_q.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL prio_timeout: tx_valid never rose (frame %0d)", n); end
      checks++; if (tid !== e_id) begin errors++; $display("FAIL prio_id: got %h exp %h", tid, e_id); end
      checks++; if (tdat !== e_d) begin errors++; $display("FAIL prio_data: got %h exp %h", tdat, e_d); end
      checks++; if (dn !== 1'b1 || ev !== e_ev) begin errors++; $display("FAIL prio_done: done %b evt %0d exp 1/%0d", dn, ev, e_ev); end
`ifdef SCHED_STATS_EN
      exp_sent++;
`endif
    end
  endtask

  task automatic test_tie();
    bit got, dn, ab; logic [ID_SIZE-1:0] tid; logic [DATA_SIZE-1:0] tdat; logic [1:0] ev;
    logic [DATA_SIZE-1:0] d1, d3, e_d; logic [1:0] e_ev;
    d1 = {$urandom, $urandom}; d3 = {$urandom, $urandom};
    exp_data_q.push_back(d1); exp_evt_q.push_back(2'd1);
    exp_data_q.push_back(d3); exp_evt_q.push_back(2'd3);
    do_load(2'd3, 11'h10A, d3);
    do_load(2'd1, 11'h10A, d1);
    for (int n = 0; n < 2; n++) begin
      serve(1'b1, 1'b0, got, tid, tdat, dn, ab, ev);
      e_d = exp_data_q.pop_front(); e_ev = exp_evt_q.pop_front();
      checks++; if (!got || tid !== 11'h10A) begin errors++; $display("FAIL tie_id: got %h (valid %b) exp 10a", tid, got); end
      checks++; if (tdat !== e_d) begin errors++; $display("FAIL tie_data: got %h exp %h", tdat, e_d); end
      checks++; if (dn !== 1'b1 || ev !== e_ev) begin errors++; $display("FAIL tie_done: done %b evt %0d exp 1/%0d", dn, ev, e_ev); end
`ifdef SCHED_STATS_EN
      exp_sent++;
`endif
    end
  endtask

  task automatic test_preempt();
    bit got, dn, ab; logic [ID_SIZE-1:0] tid; logic [DATA_SIZE-1:0] tdat; logic [1:0] ev;
    logic [ID_SIZE-1:0] e_id;
    exp_id_q.push_back(11'h200);
    exp_id_q.push_back(11'h001);
    exp_id_q.push_back(11'h200);
    exp_id_q.push_back(11'h200);
    do_load(2'd0, 11'h200, 64'h0000_0000_0000_0200);
    wait_valid(got);
    e_id = exp_id_q.pop_front();
    checks++; if (!got || Tx_ID !== e_id) begin errors++; $display("FAIL preempt_first: got %h (valid %b) exp %h", Tx_ID, got, e_id); end
    request();
    // Failure of mbox0 and load of a lower ID into mbox3 on the same edge.
    Retransmit = 1'b1;
    load_valid = 1'b1; load_idx = 2'd3; load_id = 11'h001; load_data = 64'h1;
    @(negedge clock);
    Retransmit = 1'b0; load_valid = 1'b0;
`ifdef SCHED_STATS_EN
    exp_retry++;
`endif
    checks++; if (done_pulse !== 1'b0 || abort_pulse !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL preempt_retry: done %b abort %b valid %b exp 000", done_pulse, abort_pulse, tx_valid); end
    wait_valid(got);
    checks++; if (mbox_pending !== 4'b1001) begin errors++; $display("FAIL preempt_pending: got %b exp 1001", mbox_pending); end
    serve(1'b1, 1'b0, got, tid, tdat, dn, ab, ev);
    e_id = exp_id_q.pop_front();
    checks++; if (!got || tid !== e_id) begin errors++; $display("FAIL preempt_winner: got %h exp %h", tid, e_id); end
    checks++; if (dn !== 1'b1 || ev !== 2'd3) begin errors++; $display("FAIL preempt_done: done %b evt %0d exp 1/3", dn, ev); end
`ifdef SCHED_STATS_EN
    exp_sent++;
`endif
    // mbox0 already used one attempt: one more retry, then the abort.
    serve(1'b0, 1'b1, got, tid, tdat, dn, ab, ev);
    e_id = exp_id_q.pop_front();
    checks++; if (!got || tid !== e_id || ab !== 1'b0) begin errors++; $display("FAIL preempt_second: id %h abort %b exp %h/0", tid, ab, e_id); end
`ifdef SCHED_STATS_EN
    exp_retry++;
`endif
    serve(1'b0, 1'b1, got, tid, tdat, dn, ab, ev);
    e_id = exp_id_q.pop_front();
    checks++; if (!got || tid !== e_id || ab !== 1'b1 || ev !== 2'd0) begin errors++; $display("FAIL preempt_abort: id %h abort %b evt %0d exp %h/1/0", tid, ab, ev, e_id); end
`ifdef SCHED_STATS_EN
    exp_abort++;
`endif
  endtask

  task automatic test_abort();
    bit got, dn, ab; logic [ID_SIZE-1:0] tid; logic [DATA_SIZE-1:0] tdat; logic [1:0] ev;
    do_load(2'd1, 11'h0AB, 64'hAB);
    for (int a = 0; a < 3; a++) begin
      serve(1'b0, 1'b1, got, tid, tdat, dn, ab, ev);
      checks++; if (!got || tid !== 11'h0AB) begin errors++; $display("FAIL abort_attempt: attempt %0d id %h valid %b exp 0ab", a, tid, got); end
      checks++; if (ab !== (a == 2) || dn !== 1'b0) begin errors++; $display("FAIL abort_pulse: attempt %0d abort %b done %b exp %b/0", a, ab, dn, a == 2); end
`ifdef SCHED_STATS_EN
      if (a == 2) exp_abort++; else exp_retry++;
`endif
    end
    checks++; if (ev !== 2'd1 || mbox_pending !== 4'b0) begin errors++; $display("FAIL abort_evt: evt %0d pending %b exp 1/0000", ev, mbox_pending); end
    repeat (6) @(negedge clock);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_no_fourth: tx_valid got %b exp 0", tx_valid); end
  endtask

  task automatic test_lock();
    bit got;
    logic [DATA_SIZE-1:0] dx;
    dx = {$urandom, $urandom};
    finish_attempt(1'b1, 1'b1);   // outside IN_FLIGHT: no effect
    checks++; if (done_pulse !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL idle_ignore: done %b abort %b exp 00", done_pulse, abort_pulse); end
    do_load(2'd2, 11'h055, dx);
    wait_valid(got);
    load_idx = 2'd2; #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL lock_ready: got %b exp 0", load_ready); end
    load_idx = 2'd1; #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL lock_other: got %b exp 1", load_ready); end
    @(negedge clock);
    do_load(2'd2, 11'h007, ~dx);  // must be ignored
    request();
    finish_attempt(1'b0, 1'b1);
`ifdef SCHED_STATS_EN
    exp_retry++;
`endif
    wait_valid(got);
    checks++; if (!got || Tx_ID !== 11'h055 || In_packet !== dx) begin errors++; $display("FAIL lock_unchanged: id %h data %h exp 055/%h", Tx_ID, In_packet, dx); end
    request();
    finish_attempt(1'b1, 1'b1);
`ifdef SCHED_STATS_EN
    exp_sent++;
`endif
    checks++; if (done_pulse !== 1'b1 || abort_pulse !== 1'b0 || evt_idx !== 2'd2) begin errors++; $display("FAIL conflict: done %b abort %b evt %0d exp 1/0/2", done_pulse, abort_pulse, evt_idx); end
    checks++; if (mbox_pending !== 4'b0) begin errors++; $display("FAIL conflict_pending: got %b exp 0000", mbox_pending); end
  endtask

  task automatic test_reset_mid();
    bit got;
    do_load(2'd0, 11'h3C3, 64'h3C3);
    do_load(2'd1, 11'h3C4, 64'h3C4);
    wait_valid(got);
    request();
`ifdef SCHED_STATS_EN
    checks++; if (stat_sent !== 16'(exp_sent) || stat_retry !== 16'(exp_retry) || stat_abort !== 16'(exp_abort)) begin errors++; $display("FAIL stats: got %0d/%0d/%0d exp %0d/%0d/%0d", stat_sent, stat_retry, stat_abort, exp_sent, exp_retry, exp_abort); end
`endif
    checks++; if (fsm_state !== IN_FLIGHT) begin errors++; $display("FAIL mid_state: got %0d exp %0d", fsm_state, IN_FLIGHT); end
    reset = 1'b0; #1;
    checks++; if (tx_valid !== 1'b0 || Tx_ID !== '0 || In_packet !== '0) begin errors++; $display("FAIL mid_outputs: valid %b id %h data %h exp 0", tx_valid, Tx_ID, In_packet); end
    checks++; if (mbox_pending !== 4'b0 || done_pulse !== 1'b0 || abort_pulse !== 1'b0 || evt_idx !== 2'd0) begin errors++; $display("FAIL mid_pending: pending %b done %b abort %b evt %0d exp 0", mbox_pending, done_pulse, abort_pulse, evt_idx); end
`ifdef SCHED_STATS_EN
    checks++; if (stat_sent !== 16'd0 || stat_retry !== 16'd0 || stat_abort !== 16'd0) begin errors++; $display("FAIL mid_stats: got %0d/%0d/%0d exp 0", stat_sent, stat_retry, stat_abort); end
`endif
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (tx_valid !== 1'b0 || done_pulse !== 1'b0) begin errors++; $display("FAIL mid_after: valid %b done %b exp 00", tx_valid, done_pulse); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; errors = 0;
`ifdef SCHED_STATS_EN
    exp_sent = 0; exp_retry = 0; exp_abort = 0;
`endif
    reset = 1'b0; load_valid = 1'b0; load_idx = '0; load_id = '0; load_data = '0;
    data_in_req = 1'b0; Retransmit = 1'b0; tx_ok = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_priority();
    test_tie();
    test_preempt();
    test_abort();
    test_lock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
